// File: rtl/rams_pkg.sv
// Shared types and default constants for the replicated-bank register file.
package rams_pkg;

  typedef enum logic {
    RF_IDLE,
    RF_INIT
  } rf_state_e;

  localparam int MAX_RD_PORTS = 4;

  localparam logic [31:0] RF_SP_INIT = 32'h4000_0000;
  localparam logic [31:0] RF_TP_INIT = 32'h1000_0000;
  localparam int          RF_SP_ADDR = 2;
  localparam int          RF_TP_ADDR = 4;

endpackage

// File: rtl/rams_regfile_bank.sv
// Simple-dual-port block-RAM bank: one write port, one registered read port
// with synchronous clear on the read register only.
module rams_regfile_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  clr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/rams_regfile_nr1w.sv
// NUM_RD-read / 1-write register file with clear-and-preload init sequencer.
// Define RAMS_REGFILE_BYPASS_EN for write-first forwarding on same-edge reads.
module rams_regfile_nr1w
  import rams_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_DEPTH = 32,
  parameter int                    NUM_RD     = 2,
  parameter int                    ZERO_REG   = 1,
  parameter int                    INIT_ADDR0 = RF_SP_ADDR,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL0  = DATA_WIDTH'(RF_SP_INIT),
  parameter int                    INIT_ADDR1 = RF_TP_ADDR,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL1  = DATA_WIDTH'(RF_TP_INIT)
) (
  input  logic                         clk,
  input  logic                         hwrst,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [NUM_RD-1:0]            rd_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic                         init_busy
);

  if (NUM_RD < 1 || NUM_RD > MAX_RD_PORTS) begin : g_bad_rd
    $error("NUM_RD out of range");
  end

  function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) < 32'(DATA_DEPTH);
  endfunction

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DATA_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] A0   = ADDR_WIDTH'(INIT_ADDR0);
  localparam logic [ADDR_WIDTH-1:0] A1   = ADDR_WIDTH'(INIT_ADDR1);

  rf_state_e             state;
  rf_state_e             state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  we;
  logic                  idle_we;
  logic [ADDR_WIDTH-1:0] wa;
  logic [DATA_WIDTH-1:0] wd;
  logic                  clr;

  always_ff @(posedge clk) begin
    if (hwrst) begin
      state <= RF_INIT;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (hwrst) begin
      cnt <= '0;
    end else if (state == RF_INIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == RF_INIT && cnt == LAST) begin
      state_nx = RF_IDLE;
    end
  end

  always_comb begin
    init_busy = (state == RF_INIT);
    idle_we   = (state == RF_IDLE) && !hwrst && wr_en
              && !is_zero(wr_addr) && in_rng(wr_addr);
    we        = idle_we;
    wa        = wr_addr;
    wd        = wr_data;
    if (state == RF_INIT && !hwrst) begin
      we = 1'b1;
      wa = cnt;
      if (cnt == A0) begin
        wd = INIT_VAL0;
      end else if (cnt == A1) begin
        wd = INIT_VAL1;
      end else begin
        wd = '0;
      end
    end
  end

  assign clr = hwrst | rst | (state == RF_INIT);

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] q;
    logic                  zq;

    assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

    rams_regfile_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_DEPTH(DATA_DEPTH)
    ) u_bank (
      .clk  (clk),
      .we   (we),
      .waddr(wa),
      .wdata(wd),
      .re   (rd_en[i]),
      .raddr(ra),
      .clr  (clr),
      .rdata(q)
    );

    // Masking is registered alongside the bank read to keep 1-cycle latency.
    always_ff @(posedge clk) begin
      if (clr) begin
        zq <= 1'b0;
      end else if (rd_en[i]) begin
        zq <= is_zero(ra) || !in_rng(ra);
      end
    end

`ifdef RAMS_REGFILE_BYPASS_EN
    logic                  bh;
    logic [DATA_WIDTH-1:0] bd;

    always_ff @(posedge clk) begin
      if (clr) begin
        bh <= 1'b0;
      end else if (rd_en[i]) begin
        bh <= idle_we && (wr_addr == ra);
      end
    end

    always_ff @(posedge clk) begin
      if (rd_en[i]) begin
        bd <= wr_data;
      end
    end

    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] =
      zq ? '0 : (bh ? bd : q);
`else
    assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = zq ? '0 : q;
`endif
  end

endmodule

// File: tb/tb_rams_regfile_nr1w.sv
// Directed self-checking bench for rams_regfile_nr1w (default parameters).
module tb_rams_regfile_nr1w;

  logic        clk = 1'b0;
  logic        hwrst = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  rd_en = '0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic        init_busy;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] SP = 32'h4000_0000;
  localparam logic [31:0] TP = 32'h1000_0000;

  rams_regfile_nr1w dut (
    .clk      (clk),
    .hwrst    (hwrst),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_en   = 2'b11;
    rd_addr = {a1, a0};
    tick();
    rd_en = 2'b00;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic test_reset();
    int n;
    hwrst = 1'b1;
    rd_en = 2'b11;
    repeat (3) tick();
    chk("reset_rd_data_p0", rd_data[31:0], 32'h0);
    chk("reset_rd_data_p1", rd_data[63:32], 32'h0);
    chk("reset_busy", {31'b0, init_busy}, 32'h1);
    hwrst = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (init_busy) begin
        tests++;
        if (rd_data !== 64'h0) begin
          fails++;
          $display("FAIL init_rd_zero: got %h expected 0", rd_data);
        end
      end
    end while (init_busy && n < 64);
    chk("busy_edges", n, 32);
    chk("busy_low", {31'b0, init_busy}, 32'h0);
    rd_en = 2'b00;
  endtask

  task automatic test_preload();
    rd(5'd2, 5'd4);
    chk("pre_sp_p0", rd_data[31:0], SP);
    chk("pre_tp_p1", rd_data[63:32], TP);
    rd(5'd7, 5'd7);
    chk("pre_7_p0", rd_data[31:0], 32'h0);
    chk("pre_7_p1", rd_data[63:32], 32'h0);
    rd(5'd4, 5'd2);
    chk("pre_tp_p0", rd_data[31:0], TP);
    chk("pre_sp_p1", rd_data[63:32], SP);
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd5);
    chk("wr5_p0", rd_data[31:0], 32'hDEAD_BEEF);
    chk("wr5_p1", rd_data[63:32], 32'hDEAD_BEEF);
  endtask

  task automatic test_zero_reg();
    wr(5'd0, 32'h1234_5678);
    rd(5'd0, 5'd5);
    chk("zero_p0", rd_data[31:0], 32'h0);
    chk("zero_other_p1", rd_data[63:32], 32'hDEAD_BEEF);
    rd(5'd5, 5'd0);
    chk("zero_p1", rd_data[63:32], 32'h0);
  endtask

  task automatic test_hold();
    rd(5'd2, 5'd4);
    rd_en   = 2'b01;
    rd_addr = {5'd7, 5'd5};
    tick();
    rd_en = 2'b00;
    chk("hold_p0_upd", rd_data[31:0], 32'hDEAD_BEEF);
    chk("hold_p1_keep", rd_data[63:32], TP);
    rd_addr = {5'd0, 5'd0};
    tick();
    chk("hold_idle_p0", rd_data[31:0], 32'hDEAD_BEEF);
  endtask

  task automatic test_same_edge();
    logic [31:0] exp;
`ifdef RAMS_REGFILE_BYPASS_EN
    exp = 32'hA5A5_A5A5;
`else
    exp = 32'h1;
`endif
    wr(5'd9, 32'h1);
    wr_en   = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'hA5A5_A5A5;
    rd_en   = 2'b11;
    rd_addr = {5'd9, 5'd9};
    tick();
    wr_en = 1'b0;
    rd_en = 2'b00;
    chk("same_edge_p0", rd_data[31:0], exp);
    chk("same_edge_p1", rd_data[63:32], exp);
    rd(5'd9, 5'd9);
    chk("after_same_p0", rd_data[31:0], 32'hA5A5_A5A5);
    chk("after_same_p1", rd_data[63:32], 32'hA5A5_A5A5);
  endtask

  task automatic test_soft_rst();
    rd(5'd2, 5'd2);
    chk("pre_rst_sp", rd_data[31:0], SP);
    rst     = 1'b1;
    rd_en   = 2'b11;
    rd_addr = {5'd2, 5'd2};
    tick();
    rst   = 1'b0;
    rd_en = 2'b00;
    chk("rst_p0", rd_data[31:0], 32'h0);
    chk("rst_p1", rd_data[63:32], 32'h0);
    chk("rst_busy", {31'b0, init_busy}, 32'h0);
    rd(5'd2, 5'd5);
    chk("post_rst_sp", rd_data[31:0], SP);
    chk("post_rst_5", rd_data[63:32], 32'hDEAD_BEEF);
  endtask

  task automatic test_mid_init();
    int n;
    hwrst = 1'b1;
    tick();
    hwrst   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hFFFF_FFFF;
    rd_en   = 2'b11;
    rd_addr = {5'd5, 5'd2};
    repeat (10) tick();
    chk("mid_busy", {31'b0, init_busy}, 32'h1);
    hwrst = 1'b1;
    tick();
    hwrst = 1'b0;
    n = 0;
    do begin
      wr_addr = 5'(7 + (n % 3));
      wr_en   = n[0];
      tick();
      n++;
    end while (init_busy && n < 64);
    wr_en = 1'b0;
    rd_en = 2'b00;
    chk("mid_busy_edges", n, 32);
    chk("mid_rd_zero", rd_data[31:0], 32'h0);
    rd(5'd5, 5'd7);
    chk("mid_5", rd_data[31:0], 32'h0);
    chk("mid_7", rd_data[63:32], 32'h0);
    rd(5'd9, 5'd2);
    chk("mid_9", rd_data[31:0], 32'h0);
    chk("mid_sp", rd_data[63:32], SP);
    rd(5'd4, 5'd8);
    chk("mid_tp", rd_data[31:0], TP);
    chk("mid_8", rd_data[63:32], 32'h0);
  endtask

  initial begin
    tick();
    test_reset();
    test_preload();
    test_write_read();
    test_zero_reg();
    test_hold();
    test_same_edge();
    test_soft_rst();
    test_mid_init();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
